// File: rtl/vga_timing_pkg.sv
// Shared raster timing presets and colour-bar definitions for the VGA timing generator.
package vga_timing_pkg;

    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FP     = 40;
    localparam int VGA800_H_SYNC   = 128;
    localparam int VGA800_H_BP     = 88;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FP     = 1;
    localparam int VGA800_V_SYNC   = 4;
    localparam int VGA800_V_BP     = 23;

    localparam int COLOR_W_DEFAULT = 10;

    // Bit order is {R, G, B}; each bit saturates a whole channel.
    typedef enum logic [2:0] {
        BAR_BLACK   = 3'b000,
        BAR_BLUE    = 3'b001,
        BAR_GREEN   = 3'b010,
        BAR_CYAN    = 3'b011,
        BAR_RED     = 3'b100,
        BAR_MAGENTA = 3'b101,
        BAR_YELLOW  = 3'b110,
        BAR_WHITE   = 3'b111
    } bar_rgb_e;

    function automatic bar_rgb_e bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay with synchronous clear; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctl;
            assign unused_ctl = clk ^ rst;
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= din;
                    for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign dout = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with host-latency alignment of sync, blank and colour.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 11,
    parameter int COLOR_W  = COLOR_W_DEFAULT,
    parameter int HOST_LAT = 1
) (
    input  logic               iCLK,
    input  logic               iRST,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               iTest,
`endif
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic [CNT_W-1:0]   px,
    output logic [CNT_W-1:0]   py,
    output logic               active,
    output logic               frame_start,
    output logic               line_start,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               VGA_H_SYNC,
    output logic               VGA_V_SYNC,
    output logic               VGA_BLANK,
    output logic               VGA_SYNC
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + CNT_W'(1);
        end else begin
            hc <= hc + CNT_W'(1);
        end
    end

    // Stage 0: registered coordinate, strobes and raw (active-high) sync flags
    logic hs_p0;
    logic vs_p0;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            px          <= '0;
            py          <= '0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            hs_p0       <= 1'b0;
            vs_p0       <= 1'b0;
        end else begin
            px          <= hc;
            py          <= vc;
            active      <= (hc < H_ACT_C) && (vc < V_ACT_C);
            frame_start <= (hc == '0) && (vc == '0);
            line_start  <= (hc == '0);
            hs_p0       <= (hc >= HS_BEG) && (hc < HS_END);
            vs_p0       <= (vc >= VS_BEG) && (vc < VS_END);
        end
    end

    // Stage 1..HOST_LAT: control waits for the host colour to arrive
    logic [2:0] ctl_p1;

    vga_delay_line #(
        .WIDTH(3),
        .DEPTH(HOST_LAT)
    ) u_ctl_dly (
        .clk (iCLK),
        .rst (iRST),
        .din ({hs_p0, vs_p0, active}),
        .dout(ctl_p1)
    );

    logic [COLOR_W-1:0] src_r;
    logic [COLOR_W-1:0] src_g;
    logic [COLOR_W-1:0] src_b;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

    logic [CNT_W-1:0] px_p1;
    logic [2:0]       bar_sel;
    logic [2:0]       bar;

    vga_delay_line #(
        .WIDTH(CNT_W),
        .DEPTH(HOST_LAT)
    ) u_px_dly (
        .clk (iCLK),
        .rst (iRST),
        .din (px),
        .dout(px_p1)
    );

    always_comb begin
        bar_sel = 3'(px_p1 / BAR_W);
        bar     = bar_color(bar_sel);
        src_r   = iRed;
        src_g   = iGreen;
        src_b   = iBlue;
        if (iTest) begin
            src_r = {COLOR_W{bar[2]}};
            src_g = {COLOR_W{bar[1]}};
            src_b = {COLOR_W{bar[0]}};
        end
    end
`else
    assign src_r = iRed;
    assign src_g = iGreen;
    assign src_b = iBlue;
`endif

    // Output stage: polarity applied and colour masked outside the visible area
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            VGA_R      <= '0;
            VGA_G      <= '0;
            VGA_B      <= '0;
            VGA_BLANK  <= 1'b0;
            VGA_H_SYNC <= ~HS_POL;
            VGA_V_SYNC <= ~VS_POL;
        end else begin
            VGA_H_SYNC <= ctl_p1[2] ? HS_POL : ~HS_POL;
            VGA_V_SYNC <= ctl_p1[1] ? VS_POL : ~VS_POL;
            VGA_BLANK  <= ctl_p1[0];
            VGA_R      <= ctl_p1[0] ? src_r : '0;
            VGA_G      <= ctl_p1[0] ? src_g : '0;
            VGA_B      <= ctl_p1[0] ? src_b : '0;
        end
    end

    assign VGA_SYNC = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster with HOST_LAT=2 and mixed sync polarity.
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int H_TOTAL  = 24;
    localparam int V_TOTAL  = 10;
    localparam bit HS_POL   = 1'b1;
    localparam bit VS_POL   = 1'b0;
    localparam int CNT_W    = 6;
    localparam int COLOR_W  = 10;
    localparam int HOST_LAT = 2;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } rgb_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic [5:0] x;
    } vga_t;

    logic clk = 1'b0;
    logic iRST = 1'b1;
    logic iTest = 1'b0;
    logic [COLOR_W-1:0] iRed = '0, iGreen = '0, iBlue = '0;
    logic [CNT_W-1:0] px, py;
    logic active, frame_start, line_start;
    logic [COLOR_W-1:0] VGA_R, VGA_G, VGA_B;
    logic VGA_H_SYNC, VGA_V_SYNC, VGA_BLANK, VGA_SYNC;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CNT_W(CNT_W), .COLOR_W(COLOR_W),
        .HOST_LAT(HOST_LAT)
    ) dut (
        .iCLK(clk),
        .iRST(iRST),
`ifdef VGA_TEST_PATTERN_EN
        .iTest(iTest),
`endif
        .iRed(iRed),
        .iGreen(iGreen),
        .iBlue(iBlue),
        .px(px),
        .py(py),
        .active(active),
        .frame_start(frame_start),
        .line_start(line_start),
        .VGA_R(VGA_R),
        .VGA_G(VGA_G),
        .VGA_B(VGA_B),
        .VGA_H_SYNC(VGA_H_SYNC),
        .VGA_V_SYNC(VGA_V_SYNC),
        .VGA_BLANK(VGA_BLANK),
        .VGA_SYNC(VGA_SYNC)
    );

    vga_t vq[$];
    rgb_t hq[$];
    int   mhc, mvc, cmode;
    logic tp_on = 1'b0;
    int   exp_px, exp_py;
    logic exp_act, exp_fs, exp_ls;
    vga_t exp_v;
    int   n_vec = 0, n_err = 0;

    logic [2*CNT_W+2:0] got_s0, want_s0;
    logic [32:0]        got_v, want_v;
    logic [32:0]        reset_v;

    function automatic vga_t idle_rec();
        vga_t v;
        v = '0;
        v.hs = !HS_POL;
        v.vs = !VS_POL;
        return v;
    endfunction

    function automatic rgb_t bar_model(input int x);
        rgb_t c;
        logic [2:0] m;
        case (x / (H_ACTIVE / 8))
            0: m = 3'b111;
            1: m = 3'b110;
            2: m = 3'b011;
            3: m = 3'b010;
            4: m = 3'b101;
            5: m = 3'b100;
            6: m = 3'b001;
            default: m = 3'b000;
        endcase
        c.r = {10{m[2]}};
        c.g = {10{m[1]}};
        c.b = {10{m[0]}};
        return c;
    endfunction

    // Advance one clock, update the model and drive the host colour for the next edge.
    task automatic tick();
        rgb_t c;
        rgb_t pat;
        vga_t e;
        @(posedge clk);
        @(negedge clk);
        if (iRST) begin
            mhc = 0;
            mvc = 0;
            vq.delete();
            hq.delete();
            for (int i = 0; i <= HOST_LAT; i++) vq.push_back(idle_rec());
            exp_px = 0; exp_py = 0;
            exp_act = 1'b0; exp_fs = 1'b0; exp_ls = 1'b0;
            exp_v = idle_rec();
        end else begin
            exp_px  = mhc;
            exp_py  = mvc;
            exp_act = (mhc < H_ACTIVE) && (mvc < V_ACTIVE);
            exp_fs  = (mhc == 0) && (mvc == 0);
            exp_ls  = (mhc == 0);
            case (cmode)
                0: begin c.r = 10'(mhc); c.g = 10'(mvc * 37); c.b = 10'(mhc ^ 'h155); end
                1: begin c.r = 10'h3FF; c.g = 10'h3FF; c.b = 10'h3FF; end
                default: begin c.r = 10'($urandom); c.g = 10'($urandom); c.b = 10'($urandom); end
            endcase
            hq.push_back(c);
            e.hs = (mhc >= H_ACTIVE + H_FP && mhc < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : !HS_POL;
            e.vs = (mvc >= V_ACTIVE + V_FP && mvc < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : !VS_POL;
            e.blank = exp_act;
            e.x = 6'(mhc);
            pat = tp_on ? bar_model(mhc) : c;
            e.r = exp_act ? pat.r : '0;
            e.g = exp_act ? pat.g : '0;
            e.b = exp_act ? pat.b : '0;
            vq.push_back(e);
            exp_v = vq.pop_front();
            if (mhc == H_TOTAL - 1) begin
                mhc = 0;
                mvc = (mvc == V_TOTAL - 1) ? 0 : mvc + 1;
            end else begin
                mhc = mhc + 1;
            end
        end
        if (hq.size() > HOST_LAT) c = hq.pop_front();
        else begin c.r = 10'($urandom); c.g = 10'($urandom); c.b = 10'($urandom); end
        iRed = c.r; iGreen = c.g; iBlue = c.b;
        got_s0  = {px, py, active, frame_start, line_start};
        want_s0 = {6'(exp_px), 6'(exp_py), exp_act, exp_fs, exp_ls};
        got_v   = {VGA_H_SYNC, VGA_V_SYNC, VGA_BLANK, VGA_R, VGA_G, VGA_B};
        want_v  = {exp_v.hs, exp_v.vs, exp_v.blank, exp_v.r, exp_v.g, exp_v.b};
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        reset_v = {!HS_POL, !VS_POL, 1'b0, 30'h0};
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({got_s0, got_v, VGA_SYNC} !== {{(2*CNT_W+3){1'b0}}, reset_v, 1'b0}) begin
                n_err++;
                $display("FAIL reset cyc=%0d got s0=%h vga=%h sync=%b want s0=0 vga=%h sync=0",
                         i, got_s0, got_v, VGA_SYNC, reset_v);
            end
        end
    endtask

    task automatic test_raster();
        int last_fs, period, nls;
        last_fs = -1; period = -1; nls = 0;
        cmode = 0;
        iRST = 1'b0;
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            tick();
            n_vec++;
            if (got_s0 !== want_s0) begin
                n_err++;
                $display("FAIL raster t=%0d got {px,py,act,fs,ls}=%h want %h", i, got_s0, want_s0);
            end
            if (frame_start) begin
                if (last_fs >= 0) period = i - last_fs;
                last_fs = i;
            end
            if (line_start && i < FRAME) nls++;
        end
        n_vec++;
        if (period !== FRAME) begin
            n_err++;
            $display("FAIL frame_period got %0d want %0d", period, FRAME);
        end
        n_vec++;
        if (nls !== V_TOTAL) begin
            n_err++;
            $display("FAIL line_starts_per_frame got %0d want %0d", nls, V_TOTAL);
        end
    endtask

    task automatic test_sync_blank();
        int hs_run, n_blank, n_vs;
        hs_run = 0; n_blank = 0; n_vs = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            n_vec++;
            if ({got_v[32:30], VGA_SYNC} !== {want_v[32:30], 1'b0}) begin
                n_err++;
                $display("FAIL sync_blank t=%0d got hs/vs/blank/sync=%b want %b",
                         i, {got_v[32:30], VGA_SYNC}, {want_v[32:30], 1'b0});
            end
            if (VGA_H_SYNC === HS_POL) hs_run++;
            else if (hs_run != 0) begin
                n_vec++;
                if (hs_run !== H_SYNC) begin
                    n_err++;
                    $display("FAIL hs_width got %0d want %0d", hs_run, H_SYNC);
                end
                hs_run = 0;
            end
            if (VGA_BLANK === 1'b1) n_blank++;
            if (VGA_V_SYNC === VS_POL) n_vs++;
        end
        n_vec++;
        if (n_blank !== H_ACTIVE * V_ACTIVE) begin
            n_err++;
            $display("FAIL blank_count got %0d want %0d", n_blank, H_ACTIVE * V_ACTIVE);
        end
        n_vec++;
        if (n_vs !== V_SYNC * H_TOTAL) begin
            n_err++;
            $display("FAIL vs_cycles got %0d want %0d", n_vs, V_SYNC * H_TOTAL);
        end
    endtask

    task automatic test_colour(input int mode, input int ncyc);
        cmode = mode;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            n_vec++;
            if (got_v !== want_v) begin
                n_err++;
                $display("FAIL colour mode=%0d t=%0d got vga=%h want %h", mode, i, got_v, want_v);
            end
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        cmode = 2;
        guard = 0;
        while (!(exp_px == 10 && exp_py == 3) && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        n_vec++;
        if (guard >= 2 * FRAME) begin
            n_err++;
            $display("FAIL mid_reset_reach got px=%0d py=%0d want 10,3", exp_px, exp_py);
        end
        iRST = 1'b1;
        tick();
        n_vec++;
        if ({got_v, px, py} !== {reset_v, 12'h0}) begin
            n_err++;
            $display("FAIL mid_reset_vals got vga=%h px=%0d py=%0d want %h 0 0", got_v, px, py, reset_v);
        end
        iRST = 1'b0;
        tick();
        n_vec++;
        if ({px, py, frame_start} !== {12'h0, 1'b1}) begin
            n_err++;
            $display("FAIL mid_reset_restart got px=%0d py=%0d fs=%b want 0 0 1", px, py, frame_start);
        end
        for (int i = 0; i < FRAME + 10; i++) begin
            tick();
            n_vec++;
            if ({got_s0, got_v} !== {want_s0, want_v}) begin
                n_err++;
                $display("FAIL after_reset t=%0d got s0=%h vga=%h want s0=%h vga=%h",
                         i, got_s0, got_v, want_s0, want_v);
            end
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        tp_on = 1'b1;
        iTest = 1'b1;
        cmode = 2;
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            n_vec++;
            if (got_v !== want_v) begin
                n_err++;
                $display("FAIL pattern t=%0d got vga=%h want %h", i, got_v, want_v);
            end
            if (exp_v.blank && (exp_v.x == 0 || exp_v.x == 2 || exp_v.x == H_ACTIVE - 1)) begin
                n_vec++;
                if (got_v[29:0] !== ((exp_v.x == 0) ? 30'h3FFFFFFF :
                                     (exp_v.x == 2) ? {10'h3FF, 10'h3FF, 10'h0} : 30'h0)) begin
                    n_err++;
                    $display("FAIL bar_pixel x=%0d got rgb=%h", exp_v.x, got_v[29:0]);
                end
            end
        end
        tp_on = 1'b0;
        iTest = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_raster();
        test_sync_blank();
        test_colour(0, FRAME);
        test_colour(1, FRAME);
        test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that replaces the fixed 640x480 sync module in the display path. It produces pixel coordinates for the colour source (maze, overlays, test logic), accepts that source's colour with a configurable pipeline latency, and drives HS, VS, BLANK, SYNC and RGB aligned to one another. It adds programmable sync polarity, frame and line strobes, and a compile-time colour-bar test pattern.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixel clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync, in lines
- HS_POL / VS_POL, 0 / 0, active level of the HS and VS pulses
- CNT_W, 11, coordinate and counter width; must hold H_TOTAL-1 and V_TOTAL-1
- COLOR_W, 10, width of each colour channel
- HOST_LAT, 1, cycles from px/py to valid iRed/iGreen/iBlue; range 0..4
- iCLK  in  1  pixel clock; all logic on the rising edge
- iRST  in  1  synchronous reset, active-high
- iRed / iGreen / iBlue  in  COLOR_W each  colour for the coordinate issued HOST_LAT cycles earlier
- px / py  out  CNT_W each  current raster coordinate, registered
- active  out  1  px/py lie inside the visible area
- frame_start  out  1  one-cycle pulse when px=0 and py=0
- line_start  out  1  one-cycle pulse when px=0 on every line
- VGA_R / VGA_G / VGA_B  out  COLOR_W each  pixel colour; 0 while blanked
- VGA_H_SYNC / VGA_V_SYNC  out  1  sync pulses at the HS_POL / VS_POL level
- VGA_BLANK  out  1  active-low blank; high only during the visible area
- VGA_SYNC  out  1  tied 0 (no sync-on-green)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is the equivalent sum of the V parameters.
- Horizontal counter hc runs 0..H_TOTAL-1 and then wraps to 0.
- Vertical counter vc increments when hc wraps and itself wraps to 0 after V_TOTAL-1.
- Segment order in both axes: active, front porch, sync, back porch.
- In the horizontal axis, sync is asserted for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. The vertical axis uses the same rule with the V parameters. The vertical sync window is decided by vc only, not by hc.
- px = hc and py = vc, including blanking intervals. active = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- Stage 0 registers px, py, active, the strobes and the raw sync/blank.
- Sync/blank then pass through a delay line of HOST_LAT+1 registers. Colour is registered once after arriving HOST_LAT cycles late. As a result, VGA_* for coordinate (x,y) all appear in the same cycle.
- While delayed blank is asserted, VGA_R/G/B are forced to 0 whatever the inputs are.
- Reset values:
  - px and py = 0
  - active, frame_start, line_start = 0
  - VGA_R/G/B = 0
  - VGA_BLANK = 0
  - VGA_H_SYNC = ~HS_POL, VGA_V_SYNC = ~VS_POL
  - VGA_SYNC = 0
- Reset clears the counters and every delay stage.
- Reset asserted mid-frame restarts the raster at (0,0) on the first cycle after release. Stale samples from the delay line are never emitted.
- Reset has priority over counting in the same cycle.

## Timing
- Cycle 0 after iRST falls: hc = 0. px/py/active/frame_start show (0,0) in cycle 1.
- VGA_* outputs for coordinate (x,y) appear HOST_LAT+1 cycles after px/py = (x,y).
- line_start and frame_start are each one cycle wide per occurrence. frame_start coincides with a line_start.
- Frame period is exactly H_TOTAL*V_TOTAL cycles: 420000 for the defaults.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - adds input iTest (1 bit).
  - With iTest=1, the colour stage ignores iRed/iGreen/iBlue.
  - It outputs 8 vertical bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black.
  - Each bar's channels are all-ones or 0. Bar index is taken from the delayed px.
- Undefined: no iTest port, and colour always comes from the inputs.

## Structure
- Package vga_timing_pkg holds:
  - default timing constants for 640x480@60 and 800x600@60
  - COLOR_W default
  - the bar colour constants
- One sub-module, vga_delay_line (parameters WIDTH, DEPTH, DEPTH=0 allowed), with synchronous active-high reset. It is instantiated for the sync/blank bundle and for px in the test-pattern path.

## Test plan
- Defaults, reset then free-run 2 frames: frame_start period 420000; HS low for 96 cycles starting 656 cycles after line_start; VS low for exactly 2 lines (1600 cycles).
- HOST_LAT=2, iRed driven combinationally from px through 2 registers: VGA_R equals px value at (x,y) for all visible x; VGA_BLANK=1 exactly 640 cycles per visible line.
- iRed=iGreen=iBlue=10'h3FF held constant: RGB is 0 whenever VGA_BLANK=0, and 10'h3FF otherwise.
- HS_POL=1, VS_POL=1, H 800/40/128/88, V 600/1/4/23: H_TOTAL 1056, V_TOTAL 628, sync pulses high; reset value of VGA_H_SYNC=0.
- iRST pulsed for 1 cycle at (300,200): next cycle VGA_* take reset values, and px/py=(0,0) one cycle after release. No colour from before reset appears afterwards.
- VGA_TEST_PATTERN_EN, iTest=1: pixel 0 is white (3FF,3FF,3FF), pixel 80 is yellow (3FF,3FF,0), pixel 639 is black.
